qsys_sysid_ext: RTL

//  Parametrised system-ID Avalon-MM slave: constant ID/timestamp words plus capability word,

---
 rtl/qsys_sysid_ext.sv | 129 ++++++++++++
 1 files changed

// File: rtl/qsys_sysid_ext.sv
// System-ID Avalon-MM slave: constant ID/timestamp/capability words, byte-writable scratch
// registers and an optional 64-bit uptime counter (enabled by defining SYSID_UPTIME_EN).
module qsys_sysid_ext #(
  parameter logic [31:0] ID_VALUE     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter int          NUM_SCRATCH  = 4,
  parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000,
  parameter int          ADDR_W       = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam logic [31:0] A_ID      = 32'd0;
  localparam logic [31:0] A_TS      = 32'd1;
  localparam logic [31:0] A_CAPS    = 32'd2;
  localparam logic [31:0] A_CTRL    = 32'd3;
  localparam logic [31:0] A_UP_LO   = 32'd4;
  localparam logic [31:0] A_UP_HI   = 32'd5;
  localparam int          A_SCRATCH = 6;

  logic [31:0] addr_ext;
  logic [31:0] rdata_d;
  logic [31:0] readdata_q;
  logic        readdatavalid_q;
  logic [31:0] scratch_q [NUM_SCRATCH];
  logic [31:0] scratch_d [NUM_SCRATCH];
  logic        cap_uptime;
  logic [31:0] up_lo;
  logic [31:0] up_hi;

  // Zero-extend so decode compares every address bit against the full map.
  assign addr_ext = 32'(address);

`ifdef SYSID_UPTIME_EN
  logic [63:0] uptime_q, uptime_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic        clear_req;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    clear_req   = write && (addr_ext == A_CTRL) && byteenable[0] && writedata[0];
    uptime_d    = clear_req ? 64'd0 : uptime_q + 64'd1;
    hi_shadow_d = hi_shadow_q;
    // Snapshot the pre-edge high word so a later UP_HI read cannot tear.
    if (read && (addr_ext == A_UP_LO)) hi_shadow_d = uptime_q[63:32];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uptime_q    <= 64'd0;
      hi_shadow_q <= 32'd0;
    end else begin
      uptime_q    <= uptime_d;
      hi_shadow_q <= hi_shadow_d;
    end
  end

  assign cap_uptime = 1'b1;
  assign up_lo      = uptime_q[31:0];
  assign up_hi      = hi_shadow_q;
`else
  assign cap_uptime = 1'b0;
  assign up_lo      = 32'd0;
  assign up_hi      = 32'd0;
`endif

  always_comb begin
    scratch_d = scratch_q;
    if (write) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (addr_ext == 32'(A_SCRATCH + i)) begin
          for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) scratch_d[i][8*b +: 8] = writedata[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rdata_d = 32'd0;
    case (addr_ext)
      A_ID:    rdata_d = ID_VALUE;
      A_TS:    rdata_d = TIMESTAMP;
      A_CAPS:  rdata_d = {23'd0, cap_uptime, 3'd0, 5'(NUM_SCRATCH)};
      A_UP_LO: rdata_d = up_lo;
      A_UP_HI: rdata_d = up_hi;
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (addr_ext == 32'(A_SCRATCH + i)) rdata_d = scratch_q[i];
        end
      end
    endcase
  end

  // NOTE: the scratch array is a small flop bank with a defined init value, so it is reset
  // element by element (a RAM-style array would be left unreset instead).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= SCRATCH_INIT;
    end else begin
      scratch_q <= scratch_d;
    end
  end

  // Read data is captured from pre-write state, giving read-before-write on collisions.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readdata_q      <= 32'd0;
      readdatavalid_q <= 1'b0;
    end else begin
      readdatavalid_q <= read;
      if (read) readdata_q <= rdata_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;

endmodule
